// File: rtl/cgra_conf_dispatcher_pkg.sv
// Shared definitions for the CGRA configuration broadcast path.
// Holds the dispatcher FSM state encoding and the configuration-word field
// layout {valid, id, payload}. The fan-out tree uses the same field helpers,
// so both sides always agree on where the valid bit and id live.
package cgra_conf_dispatcher_pkg;

    // Dispatcher FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Configuration word layout: valid is the MSB, the id sits directly
    // below it, and the payload fills the remaining low bits.
    function automatic int conf_valid_bit(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int conf_id_msb(input int data_width);
        return data_width - 2;
    endfunction

    function automatic int conf_id_lsb(input int data_width, input int id_width);
        return data_width - 1 - id_width;
    endfunction

    function automatic int conf_payload_width(input int data_width, input int id_width);
        return data_width - 1 - id_width;
    endfunction

endpackage

// File: rtl/cgra_conf_dispatcher.sv
// Configuration dispatcher feeding the CGRA broadcast fan-out tree.
// Takes a header (word count N in the low CNT_WIDTH bits) followed by N
// configuration words over valid/ready, emits one tagged word per accepted
// input onto conf_out one cycle later, and pulses done when the last word
// has travelled TREE_LATENCY register stages through the tree.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (aborts any transfer)
//   start     begin a transfer; only looked at while idle
//   in_data   header or configuration word
//   in_valid  in_data valid
//   in_ready  dispatcher accepts in_data this cycle (state-decoded)
//   conf_out  {valid, id, payload} to the fan-out tree; zero on bubbles
//   busy      high whenever a transfer is in progress
//   done      single-cycle pulse once the last word has left the tree
module cgra_conf_dispatcher
    import cgra_conf_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int TREE_LATENCY = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] conf_out,
    output logic                  busy,
    output logic                  done
);

    localparam int VALID_BIT = conf_valid_bit(DATA_WIDTH);
    localparam int ID_MSB    = conf_id_msb(DATA_WIDTH);
    localparam int ID_LSB    = conf_id_lsb(DATA_WIDTH, ID_WIDTH);
    localparam int PAYLOAD_W = conf_payload_width(DATA_WIDTH, ID_WIDTH);

    // The drain counter counts down to zero, so it is loaded with L-1 to
    // spend exactly TREE_LATENCY cycles in DRAIN.
    localparam logic [7:0] DRAIN_LOAD = (TREE_LATENCY > 0) ? 8'(TREE_LATENCY - 1) : 8'd0;
    // With a zero-latency tree there is nothing to wait for.
    localparam logic [2:0] FINISH_STATE = (TREE_LATENCY == 0) ? ST_DONE : ST_DRAIN;

    logic [2:0]            state;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [7:0]            drain_cnt;
    logic [DATA_WIDTH-1:0] conf_q;
    logic [DATA_WIDTH-1:0] conf_next;
    logic                  accept;
    logic                  unused_valid_in;

    // The incoming MSB position is overwritten with our own valid flag.
    assign unused_valid_in = in_data[VALID_BIT];

    assign in_ready = (state == ST_HEADER) || (state == ST_STREAM);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign conf_out = conf_q;

    always_comb begin
        conf_next                 = '0;
        conf_next[VALID_BIT]      = 1'b1;
        conf_next[ID_MSB:ID_LSB]  = in_data[ID_MSB:ID_LSB];
        conf_next[PAYLOAD_W-1:0]  = in_data[PAYLOAD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            drain_cnt <= '0;
            conf_q    <= '0;
        end else begin
            // Bubble unless a stream word is accepted this cycle.
            conf_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        remaining <= in_data[CNT_WIDTH-1:0];
                        if (in_data[CNT_WIDTH-1:0] == '0) begin
                            state     <= FINISH_STATE;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        conf_q    <= conf_next;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_WIDTH'(1)) begin
                            state     <= FINISH_STATE;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 8'd0) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
